// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the LED SPI master: FSM states, SPI mode constants,
// default timing parameters and a counter-width helper.
package spi_master_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_GAP
  } spi_state_t;

  // Mode 0, LSB first: SCLK idles low, slave samples on the rising edge.
  localparam bit SPI_CPOL      = 1'b0;
  localparam bit SPI_CPHA      = 1'b0;
  localparam bit SPI_LSB_FIRST = 1'b1;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_GAP_CYCLES = 4;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for SPI masters: emits a one-cycle phase_end tick every
// CLK_DIV enabled cycles; load restarts the count from zero.
module spi_clk_div
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic phase_end
);

  localparam int CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign phase_end = en && !load && (cnt == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// LED SPI master sequencer: accepts a word over valid/ready and drives a
// registered SS/SCLK/MOSI frame, LSB first, followed by an SS-high gap.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              SCLK,
  output logic              MOSI,
  output logic              SS
);

  localparam int BW = cnt_w(DATA_W);
  localparam int GW = cnt_w(GAP_CYCLES);
  // The bit counter is bumped on every LOW entry, so it reads DATA_W during
  // the LOW phase that follows the last bit.
  localparam logic [BW-1:0] BIT_DONE = BW'(DATA_W);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  spi_state_t        state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d, shreg_shift;
  logic [BW-1:0]     bit_cnt, bit_d;
  logic [GW-1:0]     gap_cnt, gap_d;
  logic              ss_q, ss_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              div_load, div_en, phase_end;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return SPI_LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  assign shreg_shift = SPI_LSB_FIRST ? (shreg >> 1) : (shreg << 1);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .en        (div_en),
    .phase_end (phase_end)
  );

  assign tx_ready = (state == S_IDLE) && !rst;
  assign busy     = (state != S_IDLE);
  assign done     = done_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign SS       = ss_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d  = state;
    shreg_d  = shreg;
    bit_d    = bit_cnt;
    gap_d    = gap_cnt;
    ss_d     = ss_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_en   = 1'b0;

    unique case (state)
      S_IDLE: begin
        div_load = 1'b1;
        if (tx_valid && tx_ready) begin
          state_d = S_SETUP;
          shreg_d = tx_data;
          bit_d   = '0;
          ss_d    = 1'b0;
          sclk_d  = SPI_CPOL;
          mosi_d  = first_bit(tx_data);
        end
      end
      S_SETUP: begin
        div_en = 1'b1;
        if (phase_end) begin
          state_d = S_HIGH;
          sclk_d  = !SPI_CPOL;
        end
      end
      S_HIGH: begin
        div_en = 1'b1;
        if (phase_end) begin
          // MOSI only moves together with the falling SCLK edge.
          state_d = S_LOW;
          sclk_d  = SPI_CPOL;
          shreg_d = shreg_shift;
          mosi_d  = first_bit(shreg_shift);
          bit_d   = bit_cnt + 1'b1;
        end
      end
      S_LOW: begin
        div_en = 1'b1;
        if (phase_end) begin
          if (bit_cnt == BIT_DONE) begin
            state_d = S_GAP;
            ss_d    = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            gap_d   = '0;
          end else begin
            state_d = S_HIGH;
            sclk_d  = !SPI_CPOL;
          end
        end
      end
      S_GAP: begin
        div_load = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      // NOTE: the shift register is reset as well; it is only DATA_W flops and
      // a known value keeps MOSI deterministic straight out of reset.
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      ss_q    <= 1'b1;
      sclk_q  <= SPI_CPOL;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_d;
      gap_cnt <= gap_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

endmodule
